// File: rtl/ps_ecc_pkg.sv
// ps_ecc_pkg: shared types and default widths for the primary/secondary ECC codec arbiter.
//   state_e : arbiter sequencing states (IDLE, ISSUE, CAPT, RESP)
//   op_e    : operation / grant identity (ENC = write path, DEC = read path)
package ps_ecc_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_CODEWORD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT,
        RESP
    } state_e;

    typedef enum logic {
        ENC,
        DEC
    } op_e;

endpackage

// File: rtl/ps_ecc_rr_arb2.sv
// ps_ecc_rr_arb2: two-way round-robin grant between the encode and decode requesters.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_enc     : encode requester wants service
//   req_dec     : decode requester wants service
//   update      : strobe; records the current grant as last_grant
//   grant       : requester selected this cycle (meaningful when grant_valid)
//   grant_valid : at least one requester is asking
module ps_ecc_rr_arb2
    import ps_ecc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_enc,
    input  logic req_dec,
    input  logic update,
    output op_e  grant,
    output logic grant_valid
);

    op_e last_grant;

    // A contested request goes to whoever did not win last time.
    always_comb begin
        grant       = (req_enc && req_dec) ? ((last_grant == ENC) ? DEC : ENC)
                                           : (req_enc ? ENC : DEC);
        grant_valid = req_enc || req_dec;
    end

    // Resetting to DEC lets encode win the first contested round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= DEC;
        else if (update)
            last_grant <= grant;
    end

endmodule

// File: rtl/ps_ecc_codec_arbiter.sv
// ps_ecc_codec_arbiter: shares one primary/secondary ECC codec between an encode and a decode requester.
//   clk, rst_n               : clock, asynchronous active-low reset (shared with the codec)
//   enc_req_*                : encode request channel (valid/ready, data)
//   enc_rsp_*                : encode response channel (valid/ready, codeword)
//   dec_req_*                : decode request channel (valid/ready, codeword)
//   dec_rsp_*                : decode response channel (valid/ready, data, error)
//   cdc_*                    : connection to the single codec instance
//   err_count                : saturating count of decodes that reported an error
// Optional feature: define PS_ECC_ARB_ERR_CNT_EN to build the error counter; otherwise err_count is 0.
module ps_ecc_codec_arbiter
    import ps_ecc_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int CODEWORD_WIDTH = DEF_CODEWORD_WIDTH,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enc_req_valid,
    output logic                      enc_req_ready,
    input  logic [DATA_WIDTH-1:0]     enc_req_data,
    output logic                      enc_rsp_valid,
    input  logic                      enc_rsp_ready,
    output logic [CODEWORD_WIDTH-1:0] enc_rsp_codeword,
    input  logic                      dec_req_valid,
    output logic                      dec_req_ready,
    input  logic [CODEWORD_WIDTH-1:0] dec_req_codeword,
    output logic                      dec_rsp_valid,
    input  logic                      dec_rsp_ready,
    output logic [DATA_WIDTH-1:0]     dec_rsp_data,
    output logic                      dec_rsp_error,
    output logic                      cdc_encode_en,
    output logic                      cdc_decode_en,
    output logic [DATA_WIDTH-1:0]     cdc_data_in,
    output logic [CODEWORD_WIDTH-1:0] cdc_codeword_in,
    input  logic [CODEWORD_WIDTH-1:0] cdc_codeword_out,
    input  logic [DATA_WIDTH-1:0]     cdc_data_out,
    input  logic                      cdc_error_detected,
    output logic [ERR_CNT_WIDTH-1:0]  err_count
);

    state_e state;
    op_e    op;
    op_e    grant;
    logic   grant_valid;
    logic   enc_hs;
    logic   dec_hs;
    logic   rsp_hs;

    ps_ecc_rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_enc     (enc_req_valid),
        .req_dec     (dec_req_valid),
        .update      (enc_hs || dec_hs),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Readies are gated by rst_n so nothing is offered while reset is asserted.
    assign enc_req_ready = rst_n && (state == IDLE) && grant_valid && (grant == ENC);
    assign dec_req_ready = rst_n && (state == IDLE) && grant_valid && (grant == DEC);
    assign enc_hs        = enc_req_valid && enc_req_ready;
    assign dec_hs        = dec_req_valid && dec_req_ready;
    assign rsp_hs        = (enc_rsp_valid && enc_rsp_ready) || (dec_rsp_valid && dec_rsp_ready);

    // The cdc_* input registers double as the operand latch: loaded on accept,
    // presented for the single ISSUE cycle, then cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            op               <= ENC;
            cdc_encode_en    <= 1'b0;
            cdc_decode_en    <= 1'b0;
            cdc_data_in      <= '0;
            cdc_codeword_in  <= '0;
            enc_rsp_valid    <= 1'b0;
            enc_rsp_codeword <= '0;
            dec_rsp_valid    <= 1'b0;
            dec_rsp_data     <= '0;
            dec_rsp_error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_hs || dec_hs) begin
                        op              <= dec_hs ? DEC : ENC;
                        cdc_encode_en   <= enc_hs;
                        cdc_decode_en   <= dec_hs;
                        cdc_data_in     <= enc_hs ? enc_req_data : '0;
                        cdc_codeword_in <= dec_hs ? dec_req_codeword : '0;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    cdc_encode_en   <= 1'b0;
                    cdc_decode_en   <= 1'b0;
                    cdc_data_in     <= '0;
                    cdc_codeword_in <= '0;
                    state           <= CAPT;
                end
                CAPT: begin
                    if (op == ENC) begin
                        enc_rsp_codeword <= cdc_codeword_out;
                        enc_rsp_valid    <= 1'b1;
                    end else begin
                        dec_rsp_data  <= cdc_data_out;
                        dec_rsp_error <= cdc_error_detected;
                        dec_rsp_valid <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        enc_rsp_valid <= 1'b0;
                        dec_rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef PS_ECC_ARB_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if ((state == CAPT) && (op == DEC) && cdc_error_detected && (err_count != '1))
            err_count <= err_count + ERR_CNT_WIDTH'(1);
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_ps_ecc_codec_arbiter.sv
// tb_ps_ecc_codec_arbiter: scoreboard bench for ps_ecc_codec_arbiter with a behavioural codec stand-in.
module tb_ps_ecc_codec_arbiter;
    import ps_ecc_pkg::*;

    localparam int DW = 8;
    localparam int CW = 16;
    localparam int EW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enc_req_valid = 1'b0;
    logic          enc_req_ready;
    logic [DW-1:0] enc_req_data = '0;
    logic          enc_rsp_valid;
    logic          enc_rsp_ready = 1'b0;
    logic [CW-1:0] enc_rsp_codeword;
    logic          dec_req_valid = 1'b0;
    logic          dec_req_ready;
    logic [CW-1:0] dec_req_codeword = '0;
    logic          dec_rsp_valid;
    logic          dec_rsp_ready = 1'b0;
    logic [DW-1:0] dec_rsp_data;
    logic          dec_rsp_error;
    logic          cdc_encode_en;
    logic          cdc_decode_en;
    logic [DW-1:0] cdc_data_in;
    logic [CW-1:0] cdc_codeword_in;
    logic [CW-1:0] cdc_codeword_out;
    logic [DW-1:0] cdc_data_out;
    logic          cdc_error_detected;
    logic [EW-1:0] err_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_rsp = 0;
    int n_sent = 0;
    int last_acc = -1;
    int exp_err = 0;
    bit contend = 0;
    bit enc_hold = 0;
    bit dec_hold = 0;
    logic [15:0] hold_cw;
    logic [8:0]  hold_dec;

    logic [15:0] exp_enc[$];
    logic [8:0]  exp_dec[$];
    op_e         exp_op[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps_ecc_codec_arbiter #(
        .DATA_WIDTH     (DW),
        .CODEWORD_WIDTH (CW),
        .ERR_CNT_WIDTH  (EW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enc_req_valid      (enc_req_valid),
        .enc_req_ready      (enc_req_ready),
        .enc_req_data       (enc_req_data),
        .enc_rsp_valid      (enc_rsp_valid),
        .enc_rsp_ready      (enc_rsp_ready),
        .enc_rsp_codeword   (enc_rsp_codeword),
        .dec_req_valid      (dec_req_valid),
        .dec_req_ready      (dec_req_ready),
        .dec_req_codeword   (dec_req_codeword),
        .dec_rsp_valid      (dec_rsp_valid),
        .dec_rsp_ready      (dec_rsp_ready),
        .dec_rsp_data       (dec_rsp_data),
        .dec_rsp_error      (dec_rsp_error),
        .cdc_encode_en      (cdc_encode_en),
        .cdc_decode_en      (cdc_decode_en),
        .cdc_data_in        (cdc_data_in),
        .cdc_codeword_in    (cdc_codeword_in),
        .cdc_codeword_out   (cdc_codeword_out),
        .cdc_data_out       (cdc_data_out),
        .cdc_error_detected (cdc_error_detected),
        .err_count          (err_count)
    );

    // Codec stand-in: registered outputs one cycle after the enable pulse.
    // Codeword is {8'hFF, data}; any upper byte other than 8'hFF is reported as an error.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdc_codeword_out   <= '0;
            cdc_data_out       <= '0;
            cdc_error_detected <= 1'b0;
        end else begin
            if (cdc_encode_en)
                cdc_codeword_out <= {8'hFF, cdc_data_in};
            if (cdc_decode_en) begin
                cdc_data_out       <= cdc_codeword_in[7:0];
                cdc_error_detected <= (cdc_codeword_in[15:8] != 8'hFF);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-low-phase, pops expectations on response handshakes.
    initial forever begin
        @(negedge clk);
        #2;
        if (cdc_encode_en && cdc_decode_en)
            chk("en_overlap", 1, 0);
        else if (cdc_encode_en || cdc_decode_en) begin
            if (exp_op.size() == 0)
                chk("unexpected_en", 1, 0);
            else
                chk("op_order", 32'(cdc_decode_en), 32'(exp_op.pop_front()));
        end
        if ((enc_req_valid && enc_req_ready) || (dec_req_valid && dec_req_ready)) begin
            if (enc_req_ready && dec_req_ready)
                chk("ready_both", 1, 0);
            if (contend && last_acc >= 0)
                chk("accept_gap", cyc - last_acc, 4);
            last_acc = cyc;
            n_acc++;
        end
        if (enc_rsp_valid) begin
            if (enc_hold)
                chk("enc_hold", enc_rsp_codeword, hold_cw);
            if (enc_rsp_ready) begin
                if (exp_enc.size() == 0)
                    chk("enc_rsp_unexpected", 1, 0);
                else
                    chk("enc_cw", enc_rsp_codeword, exp_enc.pop_front());
                n_rsp++;
                enc_hold = 0;
            end else begin
                enc_hold = 1;
                hold_cw  = enc_rsp_codeword;
            end
        end else
            enc_hold = 0;
        if (dec_rsp_valid) begin
            if (dec_hold)
                chk("dec_hold", {dec_rsp_error, dec_rsp_data}, hold_dec);
            if (dec_rsp_ready) begin
                if (exp_dec.size() == 0)
                    chk("dec_rsp_unexpected", 1, 0);
                else
                    chk("dec_err_data", {dec_rsp_error, dec_rsp_data}, exp_dec.pop_front());
                n_rsp++;
                dec_hold = 0;
            end else begin
                dec_hold = 1;
                hold_dec = {dec_rsp_error, dec_rsp_data};
            end
        end else
            dec_hold = 0;
    end

    task automatic send(input bit is_dec, input logic [15:0] v);
        int k = 0;
        @(negedge clk);
        if (is_dec) begin
            dec_req_valid    = 1'b1;
            dec_req_codeword = v;
        end else begin
            enc_req_valid = 1'b1;
            enc_req_data  = v[7:0];
        end
        #1;
        while (!(is_dec ? dec_req_ready : enc_req_ready) && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k == 50)
            chk("req_timeout", 1, 0);
        @(posedge clk);
        #1;
        enc_req_valid = 1'b0;
        dec_req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int k = 0;
        while (n_rsp < n_sent && k < 50) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (n_rsp < n_sent)
            chk("rsp_timeout", n_rsp, n_sent);
    endtask

    task automatic do_dec(input logic [15:0] cw, input logic [7:0] d, input bit e);
        exp_dec.push_back({e, d});
        exp_op.push_back(DEC);
        n_sent++;
`ifdef PS_ECC_ARB_ERR_CNT_EN
        if (e && exp_err < 3)
            exp_err++;
`endif
        send(1'b1, cw);
        wait_rsp();
        chk("err_count", err_count, exp_err);
    endtask

    task automatic contest(input int n, input logic [7:0] d, input logic [15:0] cw);
        int k = 0;
        int base;
        base = n_acc;
        contend  = 1;
        last_acc = -1;
        @(negedge clk);
        enc_req_valid    = 1'b1;
        enc_req_data     = d;
        dec_req_valid    = 1'b1;
        dec_req_codeword = cw;
        while (n_acc < base + n && k < 100) begin
            @(negedge clk);
            #3;
            k++;
        end
        chk("contend_accepts", n_acc - base, n);
        @(posedge clk);
        #1;
        enc_req_valid = 1'b0;
        dec_req_valid = 1'b0;
        contend = 0;
        wait_rsp();
    endtask

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset: everything idle even with requests pending.
        enc_req_valid = 1'b1;
        dec_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {enc_req_ready, dec_req_ready}, 0);
        chk("rst_rsp_valid", {enc_rsp_valid, dec_rsp_valid}, 0);
        chk("rst_cdc", {cdc_encode_en, cdc_decode_en, cdc_data_in, cdc_codeword_in}, 0);
        chk("rst_err", err_count, 0);
        enc_req_valid = 1'b0;
        dec_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single encode of 0xA5, latency and hold with rsp_ready low.
        exp_enc.push_back(16'hFFA5);
        exp_op.push_back(ENC);
        n_sent++;
        send(1'b0, 16'h00A5);
        @(negedge clk);
        chk("issue_en", {cdc_encode_en, cdc_decode_en}, 2'b10);
        chk("issue_data", cdc_data_in, 8'hA5);
        chk("issue_cw_unused", cdc_codeword_in, 0);
        chk("lat_e0", enc_rsp_valid, 0);
        @(negedge clk);
        chk("lat_e1", {enc_rsp_valid, cdc_encode_en}, 0);
        @(negedge clk);
        chk("lat_e2", enc_rsp_valid, 1);
        chk("lat_cw", enc_rsp_codeword, 16'hFFA5);
        dec_req_valid    = 1'b1;
        dec_req_codeword = 16'hFFA5;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("hold_valid", enc_rsp_valid, 1);
            chk("hold_ready", {enc_req_ready, dec_req_ready}, 0);
            chk("hold_en", {cdc_encode_en, cdc_decode_en}, 0);
        end
        dec_req_valid = 1'b0;
        enc_rsp_ready = 1'b1;
        dec_rsp_ready = 1'b1;
        wait_rsp();
        @(negedge clk);
        chk("enc_valid_drop", enc_rsp_valid, 0);

        // Decodes: clean then corrupted.
        do_dec(16'hFFA5, 8'hA5, 1'b0);
        do_dec(16'hFEA5, 8'hA5, 1'b1);

        // Contested: last op was DEC, so ENC first and strict alternation.
        repeat (2) begin
            exp_op.push_back(ENC);
            exp_op.push_back(DEC);
            exp_enc.push_back(16'hFF3C);
            exp_dec.push_back({1'b0, 8'h12});
        end
        n_sent += 4;
        contest(4, 8'h3C, 16'hFF12);

        // Reset during ISSUE abandons the operation.
        @(negedge clk);
        enc_req_valid = 1'b1;
        enc_req_data  = 8'h77;
        #1;
        chk("pre_rst_ready", enc_req_ready, 1);
        @(posedge clk);
        #1;
        enc_req_valid = 1'b0;
        rst_n = 1'b0;
        exp_err = 0;
        #1;
        chk("mid_rst_out", {enc_req_ready, dec_req_ready, enc_rsp_valid, dec_rsp_valid, cdc_encode_en, cdc_decode_en}, 0);
        chk("mid_rst_cdc", {cdc_data_in, cdc_codeword_in}, 0);
        chk("mid_rst_err", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_quiet", {enc_rsp_valid, dec_rsp_valid, cdc_encode_en, cdc_decode_en}, 0);
        end
        exp_op.push_back(ENC);
        exp_op.push_back(DEC);
        exp_enc.push_back(16'hFF5A);
        exp_dec.push_back({1'b0, 8'h00});
        n_sent += 2;
        contest(2, 8'h5A, 16'hFF00);

        // Saturation of the error counter (2-bit): 5 errors -> 3.
        repeat (5) do_dec(16'hFEA5, 8'hA5, 1'b1);
        chk("err_sat", err_count, exp_err);

        repeat (3) @(negedge clk);
        chk("queues_empty", exp_enc.size() + exp_dec.size() + exp_op.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
